// File: rtl/udma_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module   : udma_uart_rx_core
//  Brief    : UART serial-to-parallel receiver with latched frame config,
//             mid-bit sampling and a valid/ready holding register.
//  Revision : 1.0 - initial release
// ============================================================================
module udma_uart_rx_core #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        rx_i,
    input  logic        cfg_en_i,
    input  logic [15:0] cfg_div_i,
    input  logic        cfg_parity_en_i,
    input  logic [1:0]  cfg_bits_i,
    input  logic        cfg_stop_bits_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        err_parity_o,
    output logic        err_overflow_o,
    output logic        busy_o
);

    // A synchronizer shorter than two flops is never safe; clamp it.
    localparam int SYNC_W = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_e;

    logic [SYNC_W-1:0] sync_q;
    logic              prev_q;
    logic              rxs;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  bits_q, bits_d;
    logic        par_en_q, par_en_d;
    logic        stop2_q, stop2_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        par_q, par_d;
    logic        perr_q, perr_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        err_par_q, err_par_d;
    logic        err_ovf_q, err_ovf_d;
    logic        busy_q, busy_d;

    logic        sample;
    logic        boundary;
    logic        last_bit;
    logic        complete;

    assign rxs      = sync_q[SYNC_W-1];
    assign sample   = (cnt_q == (div_q >> 1));
    assign boundary = (cnt_q == div_q);
    // Index of the last data bit is N-1 = 4 + cfg_bits.
    assign last_bit = (bit_idx_q == {1'b1, bits_q});

    // Metastability synchronizer for the rx pin plus previous-sample flop for edge detection.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_W-2:0], rx_i};
            prev_q <= rxs;
        end
    end

    // State, timing, shift and holding registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            bits_q    <= '0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_par_q <= 1'b0;
            err_ovf_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bits_q    <= bits_d;
            par_en_q  <= par_en_d;
            stop2_q   <= stop2_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            perr_q    <= perr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_par_q <= err_par_d;
            err_ovf_q <= err_ovf_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state: frame FSM, bit timing, then holding-register update on completion.
    always_comb begin
        state_d   = state_q;
        cnt_d     = boundary ? 16'd0 : cnt_q + 16'd1;
        div_d     = div_q;
        bits_d    = bits_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        perr_d    = perr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        err_par_d = 1'b0;
        err_ovf_d = 1'b0;
        complete  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (cfg_en_i && prev_q && !rxs) begin
                    // The detection cycle counts as cycle 0 of the start bit.
                    div_d     = cfg_div_i;
                    bits_d    = cfg_bits_i;
                    par_en_d  = cfg_parity_en_i;
                    stop2_d   = cfg_stop_bits_i;
                    bit_idx_d = 3'd0;
                    shreg_d   = 8'd0;
                    par_d     = 1'b0;
                    perr_d    = 1'b0;
                    // With div=0 the start bit is fully consumed in the detection cycle.
                    cnt_d     = (cfg_div_i == 16'd0) ? 16'd0 : 16'd1;
                    state_d   = (cfg_div_i == 16'd0) ? DATA : START;
                end
            end
            START: begin
                if (sample && rxs) begin
                    state_d = IDLE;
                end else if (boundary) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    shreg_d[bit_idx_q] = rxs;
                    par_d              = par_q ^ rxs;
                end
                if (boundary) begin
                    if (last_bit) begin
                        state_d = par_en_q ? PARITY : STOP1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (sample) begin
                    perr_d = par_q ^ rxs;
                end
                if (boundary) begin
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (sample && !rxs) begin
                    state_d = IDLE;
                end else if (sample && !stop2_q) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if (boundary && stop2_q) begin
                    state_d = STOP2;
                end
            end
            STOP2: begin
                if (sample) begin
                    complete = rxs;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disabling the receiver aborts any partial frame silently.
        if (!cfg_en_i && (state_q != IDLE)) begin
            state_d  = IDLE;
            complete = 1'b0;
        end

        if (complete) begin
            if (!valid_q || rx_ready_i) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                err_ovf_d = 1'b1;
            end
            err_par_d = perr_q;
        end else if (valid_q && rx_ready_i) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    assign rx_data_o      = data_q;
    assign rx_valid_o     = valid_q;
    assign err_parity_o   = err_par_q;
    assign err_overflow_o = err_ovf_q;
    assign busy_o         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_udma_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_udma_uart_rx_core
//  Brief    : Directed self-checking bench for the UART receiver core.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_udma_uart_rx_core;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        rx_i = 1'b1;
    logic        cfg_en_i = 1'b1;
    logic [15:0] cfg_div_i = 16'd15;
    logic        cfg_parity_en_i = 1'b0;
    logic [1:0]  cfg_bits_i = 2'b11;
    logic        cfg_stop_bits_i = 1'b0;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i = 1'b0;
    logic        err_parity_o;
    logic        err_overflow_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Free-running cycle count and event monitors used to time and count DUT outputs.
    int cyc = 0;
    int rise_cnt = 0, rise_cyc = -1;
    int par_cnt = 0, par_cyc = -1;
    int ovf_cnt = 0;
    logic last_valid = 1'b0;

    udma_uart_rx_core #(.SYNC_STAGES(2)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .rx_i           (rx_i),
        .cfg_en_i       (cfg_en_i),
        .cfg_div_i      (cfg_div_i),
        .cfg_parity_en_i(cfg_parity_en_i),
        .cfg_bits_i     (cfg_bits_i),
        .cfg_stop_bits_i(cfg_stop_bits_i),
        .rx_data_o      (rx_data_o),
        .rx_valid_o     (rx_valid_o),
        .rx_ready_i     (rx_ready_i),
        .err_parity_o   (err_parity_o),
        .err_overflow_o (err_overflow_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (rx_valid_o && !last_valid) begin
            rise_cnt = rise_cnt + 1;
            rise_cyc = cyc;
        end
        last_valid = rx_valid_o;
        if (err_parity_o) begin
            par_cnt = par_cnt + 1;
            par_cyc = cyc;
        end
        if (err_overflow_o) ovf_cnt = ovf_cnt + 1;
    end

    task automatic drive_bit(input logic b, input int div);
        rx_i = b;
        repeat (div + 1) @(posedge clk_i);
        #1;
    endtask

    // Drives one frame, then two idle-high cycles; starts and ends at posedge+1.
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                              input bit par_bit, input int nstop, input bit stop_val,
                              input int div);
        drive_bit(1'b0, div);
        for (int i = 0; i < nbits; i++) drive_bit(d[i], div);
        if (par_en) drive_bit(par_bit, div);
        for (int i = 0; i < nstop; i++) drive_bit(stop_val, div);
        rx_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic pop();
        rx_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rx_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", rx_valid_o); end
        n_checks++; if (rx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", rx_data_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        n_checks++; if (err_parity_o !== 1'b0) begin n_fail++; $display("FAIL reset_errpar got %b exp 0", err_parity_o); end
        n_checks++; if (err_overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_errovf got %b exp 0", err_overflow_o); end
        rstn_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    task automatic test_basic_8n1();
        int start_cyc, r0, p0, o0;
        cfg_div_i = 16'd15; cfg_bits_i = 2'b11; cfg_parity_en_i = 1'b0; cfg_stop_bits_i = 1'b0;
        r0 = rise_cnt; p0 = par_cnt; o0 = ovf_cnt;
        start_cyc = cyc;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 15);
        // Edge seen at start+2 after the 2-flop sync; valid rises at t0+152.
        n_checks++; if (rise_cyc !== start_cyc + 154) begin n_fail++; $display("FAIL basic_latency got %0d exp %0d", rise_cyc - start_cyc, 154); end
        n_checks++; if (rx_data_o !== 8'hA5) begin n_fail++; $display("FAIL basic_data got %h exp a5", rx_data_o); end
        n_checks++; if (rise_cnt - r0 !== 1) begin n_fail++; $display("FAIL basic_rises got %0d exp 1", rise_cnt - r0); end
        n_checks++; if ((par_cnt - p0) + (ovf_cnt - o0) !== 0) begin n_fail++; $display("FAIL basic_errs got %0d exp 0", (par_cnt - p0) + (ovf_cnt - o0)); end
        pop();
        n_checks++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_pop got %b exp 0", rx_valid_o); end
    endtask

    task automatic test_held_low();
        int r0;
        r0 = rise_cnt;
        cfg_en_i = 1'b0;
        rx_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;
        cfg_en_i = 1'b1;
        repeat (20) @(posedge clk_i);
        #1;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL held_low_busy got %b exp 0", busy_o); end
        rx_i = 1'b1;
        repeat (6) @(posedge clk_i);
        #1;
        n_checks++; if (rise_cnt - r0 !== 0) begin n_fail++; $display("FAIL held_low_rises got %0d exp 0", rise_cnt - r0); end
    endtask

    task automatic test_parity();
        int p0;
        cfg_div_i = 16'd3; cfg_bits_i = 2'b00; cfg_parity_en_i = 1'b1; cfg_stop_bits_i = 1'b1;
        // 0x13 -> 5 bits 10011 has three ones, even parity bit = 1.
        p0 = par_cnt;
        send_frame(8'h13, 5, 1'b1, 1'b1, 2, 1'b1, 3);
        n_checks++; if (rx_data_o !== 8'h13) begin n_fail++; $display("FAIL par_ok_data got %h exp 13", rx_data_o); end
        n_checks++; if (rx_valid_o !== 1'b1) begin n_fail++; $display("FAIL par_ok_valid got %b exp 1", rx_valid_o); end
        n_checks++; if (par_cnt - p0 !== 0) begin n_fail++; $display("FAIL par_ok_err got %0d exp 0", par_cnt - p0); end
        pop();
        p0 = par_cnt;
        send_frame(8'h13, 5, 1'b1, 1'b0, 2, 1'b1, 3);
        n_checks++; if (rx_data_o !== 8'h13) begin n_fail++; $display("FAIL par_bad_data got %h exp 13", rx_data_o); end
        n_checks++; if (par_cnt - p0 !== 1) begin n_fail++; $display("FAIL par_bad_pulses got %0d exp 1", par_cnt - p0); end
        n_checks++; if (par_cyc !== rise_cyc) begin n_fail++; $display("FAIL par_bad_coincide got %0d exp %0d", par_cyc, rise_cyc); end
        pop();
    endtask

    task automatic test_glitch();
        int r0, p0, o0;
        cfg_div_i = 16'd15; cfg_bits_i = 2'b11; cfg_parity_en_i = 1'b0; cfg_stop_bits_i = 1'b0;
        r0 = rise_cnt; p0 = par_cnt; o0 = ovf_cnt;
        rx_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rx_i = 1'b1;
        @(negedge clk_i);
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start got %b exp 1", busy_o); end
        repeat (6) @(negedge clk_i);
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_at_sample got %b exp 1", busy_o); end
        @(negedge clk_i);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_drop got %b exp 0", busy_o); end
        repeat (30) @(posedge clk_i);
        #1;
        n_checks++; if ((rise_cnt - r0) + (par_cnt - p0) + (ovf_cnt - o0) !== 0) begin n_fail++; $display("FAIL glitch_outputs got %0d exp 0", (rise_cnt - r0) + (par_cnt - p0) + (ovf_cnt - o0)); end
    endtask

    task automatic test_back_to_back();
        int o0;
        cfg_div_i = 16'd7; cfg_bits_i = 2'b11; cfg_parity_en_i = 1'b0; cfg_stop_bits_i = 1'b0;
        o0 = ovf_cnt;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1, 7);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1, 7);
        n_checks++; if (ovf_cnt - o0 !== 1) begin n_fail++; $display("FAIL ovf_pulses got %0d exp 1", ovf_cnt - o0); end
        n_checks++; if (rx_data_o !== 8'h11) begin n_fail++; $display("FAIL ovf_data_kept got %h exp 11", rx_data_o); end
        n_checks++; if (rx_valid_o !== 1'b1) begin n_fail++; $display("FAIL ovf_valid got %b exp 1", rx_valid_o); end
        // Pop exactly in the stop-sample cycle (t0+75 = start+77) so the new byte loads.
        o0 = ovf_cnt;
        fork
            send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1, 7);
            begin
                repeat (77) @(posedge clk_i);
                #1;
                rx_ready_i = 1'b1;
                @(posedge clk_i);
                #1;
                rx_ready_i = 1'b0;
            end
        join
        n_checks++; if (rx_data_o !== 8'h22) begin n_fail++; $display("FAIL b2b_ready_data got %h exp 22", rx_data_o); end
        n_checks++; if (rx_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_valid got %b exp 1", rx_valid_o); end
        n_checks++; if (ovf_cnt - o0 !== 0) begin n_fail++; $display("FAIL b2b_ready_ovf got %0d exp 0", ovf_cnt - o0); end
        pop();
        n_checks++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_pop got %b exp 0", rx_valid_o); end
    endtask

    task automatic test_framing();
        int r0, p0, o0;
        r0 = rise_cnt; p0 = par_cnt; o0 = ovf_cnt;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1, 1'b0, 7);
        repeat (8) @(posedge clk_i);
        #1;
        n_checks++; if ((rise_cnt - r0) + (par_cnt - p0) + (ovf_cnt - o0) !== 0) begin n_fail++; $display("FAIL framing_outputs got %0d exp 0", (rise_cnt - r0) + (par_cnt - p0) + (ovf_cnt - o0)); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL framing_busy got %b exp 0", busy_o); end
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, 7);
        n_checks++; if (rx_data_o !== 8'h3C) begin n_fail++; $display("FAIL framing_next_data got %h exp 3c", rx_data_o); end
        n_checks++; if (rx_valid_o !== 1'b1) begin n_fail++; $display("FAIL framing_next_valid got %b exp 1", rx_valid_o); end
    endtask

    task automatic test_cfg_disable();
        int r0;
        r0 = rise_cnt;
        fork
            send_frame(8'h99, 8, 1'b0, 1'b0, 1, 1'b1, 7);
            begin
                repeat (40) @(posedge clk_i);
                #1;
                n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL dis_busy_before got %b exp 1", busy_o); end
                cfg_en_i = 1'b0;
                @(posedge clk_i);
                #1;
                n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL dis_busy_after got %b exp 0", busy_o); end
            end
        join
        n_checks++; if (rx_valid_o !== 1'b1) begin n_fail++; $display("FAIL dis_valid_kept got %b exp 1", rx_valid_o); end
        n_checks++; if (rx_data_o !== 8'h3C) begin n_fail++; $display("FAIL dis_data_kept got %h exp 3c", rx_data_o); end
        n_checks++; if (rise_cnt - r0 !== 0) begin n_fail++; $display("FAIL dis_rises got %0d exp 0", rise_cnt - r0); end
        cfg_en_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    task automatic test_async_reset();
        fork
            send_frame(8'h77, 8, 1'b0, 1'b0, 1, 1'b1, 7);
            begin
                repeat (40) @(posedge clk_i);
                #3;
                n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL arst_busy_before got %b exp 1", busy_o); end
                rstn_i = 1'b0;
                #1;
                n_checks++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b exp 0", rx_valid_o); end
                n_checks++; if (rx_data_o !== 8'h00) begin n_fail++; $display("FAIL arst_data got %h exp 00", rx_data_o); end
                n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b exp 0", busy_o); end
            end
        join
        rstn_i = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        n_checks++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_after_valid got %b exp 0", rx_valid_o); end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_held_low();
        test_parity();
        test_glitch();
        test_back_to_back();
        test_framing();
        test_cfg_disable();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
